// File: rtl/mem_req_arbiter_if.sv
// Bus bundle for mem_req_arbiter.
// Carries the instruction-fetch request port, the load/store request port and the
// shared sram-like memory bus.
//   master : arbiter side (accepts requests, drives the memory bus)
//   slave  : environment side (requesters plus the memory)
interface mem_req_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    // instruction-fetch port
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;

    // load/store port
    logic              data_req;
    logic              data_wr;
    logic [STRB_W-1:0] data_wen;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    // shared memory bus
    logic              bus_req;
    logic              bus_wr;
    logic [STRB_W-1:0] bus_wstrb;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_addr_ok;
    logic              bus_data_ok;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_wen, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport slave (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_wen, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
// Shares one sram-like memory bus between the instruction-fetch port and the
// load/store port, one transaction outstanding at a time. Data requests win
// arbitration unless the fetch port has lost STARVE_MAX grants in a row. A store
// with an all-zero byte mask completes locally without touching the bus.
// Ports:
//   clk    : clock, rising edge
//   resetn : asynchronous active-low reset
//   mif    : mem_req_arbiter_if.master (request ports + memory bus)
module mem_req_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               resetn,
    mem_req_arbiter_if.master  mif
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RESP  = 2'd2,
        LOCAL = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;      // 1 = data port owns the transaction
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              wr_q, wr_d;

    logic inst_grant, data_grant;
    logic inst_ok, data_ok;

    function automatic logic [CNT_W-1:0] starve_inc(input logic [CNT_W-1:0] c);
        if (c >= CNT_MAX) return CNT_MAX;
        return c + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            starve_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            wr_q     <= wr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        starve_d   = starve_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        wr_d       = wr_q;
        inst_grant = 1'b0;
        data_grant = 1'b0;
        inst_ok    = 1'b0;
        data_ok    = 1'b0;

        case (state_q)
            IDLE: begin
                // Grants are combinational, so they are masked while reset is held.
                if (resetn) begin
                    if (mif.inst_req && (!mif.data_req || starve_q == CNT_MAX))
                        inst_grant = 1'b1;
                    else if (mif.data_req)
                        data_grant = 1'b1;
                end

                if (inst_grant) begin
                    owner_d  = 1'b0;
                    addr_d   = mif.inst_addr;
                    wdata_d  = '0;
                    wstrb_d  = '0;
                    wr_d     = 1'b0;
                    starve_d = '0;
                    state_d  = REQ;
                end else if (data_grant) begin
                    owner_d  = 1'b1;
                    addr_d   = mif.data_addr;
                    wdata_d  = mif.data_wdata;
                    wstrb_d  = mif.data_wr ? mif.data_wen : '0;
                    wr_d     = mif.data_wr;
                    // Only consecutive data wins against a waiting fetch count.
                    starve_d = mif.inst_req ? starve_inc(starve_q) : '0;
                    // A masked-off store (address exception) must not reach memory.
                    state_d  = (mif.data_wr && mif.data_wen == '0) ? LOCAL : REQ;
                end
            end
            REQ: begin
                if (mif.bus_addr_ok) state_d = RESP;
            end
            RESP: begin
                if (mif.bus_data_ok) begin
                    inst_ok = !owner_q;
                    data_ok = owner_q;
                    state_d = IDLE;
                end
            end
            LOCAL: begin
                data_ok = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mif.inst_addr_ok = inst_grant;
    assign mif.data_addr_ok = data_grant;
    assign mif.inst_data_ok = inst_ok;
    assign mif.data_data_ok = data_ok;
    // Read data is a pass-through of the bus only on a real bus response.
    assign mif.inst_rdata   = (inst_ok && state_q == RESP) ? mif.bus_rdata : '0;
    assign mif.data_rdata   = (data_ok && state_q == RESP) ? mif.bus_rdata : '0;

    assign mif.bus_req   = (state_q == REQ);
    assign mif.bus_wr    = wr_q;
    assign mif.bus_wstrb = wstrb_q;
    assign mif.bus_addr  = addr_q;
    assign mif.bus_wdata = wdata_q;
endmodule
